// File: rtl/mult_prod_accumulator_if.sv
// Handshake bundle between the multiplier product stream and the
// accumulator result stream.
interface mult_prod_accumulator_if #(
    parameter int ACC_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );
endinterface

// File: rtl/mult_prod_accumulator.sv
// Sums N_TERMS consecutive 8-bit products into an ACC_W result.
// Define MULT_ACC_SAT_EN to saturate instead of wrap.
module mult_prod_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic clk,
    input  logic rst,
    mult_prod_accumulator_if.slave bus
);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_ovf_q;

    logic             accepting;
    logic             beat;
    logic             last;
    logic [ACC_W:0]   raw;
    logic             carry;
    logic [ACC_W-1:0] sum_nx;

    // in_ready depends only on registered state
    assign accepting = (state == ST_ACC);
    assign beat      = bus.in_valid & accepting;
    assign last      = (cnt == CNT_LAST);

    assign raw   = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.in_prod};
    assign carry = raw[ACC_W];

`ifdef MULT_ACC_SAT_EN
    assign sum_nx = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    assign sum_nx = raw[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACC;
            acc         <= '0;
            cnt         <= '0;
            ovf_acc     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ST_ACC): begin
                    if (beat) begin
                        if (last) begin
                            out_sum_q   <= sum_nx;
                            out_ovf_q   <= ovf_acc | carry;
                            out_valid_q <= 1'b1;
                            state       <= ST_HOLD;
                            acc         <= '0;
                            cnt         <= '0;
                            ovf_acc     <= 1'b0;
                        end else begin
                            acc     <= sum_nx;
                            ovf_acc <= ovf_acc | carry;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                (state == ST_HOLD): begin
                    // result fields persist after the handshake
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign bus.in_ready  = accepting;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mult_prod_accumulator.sv
// Scoreboard bench for mult_prod_accumulator (default and 8-bit/2-term
// instances); honours MULT_ACC_SAT_EN.
module tb_mult_prod_accumulator;
    localparam int N    = 4;
    localparam int W    = 10;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_prod_accumulator_if #(.ACC_W(W)) bus ();
    mult_prod_accumulator_if #(.ACC_W(8)) bus2 ();

    mult_prod_accumulator #(.N_TERMS(N), .ACC_W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mult_prod_accumulator #(.N_TERMS(2), .ACC_W(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        int sum;
        bit ovf;
    } res_t;

    res_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_acc       = 0;
    int   m_cnt       = 0;
    bit   m_ovf       = 1'b0;
    bit   m_hold      = 1'b0;
    bit   mon_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref8(input int a, input int b);
        int s;
        s = a + b;
        if (s > 255) begin
`ifdef MULT_ACC_SAT_EN
            return {1'b1, 8'd255};
`else
            return {1'b1, 8'(s - 256)};
`endif
        end
        return {1'b0, 8'(s)};
    endfunction

    // Reference: a running total of accepted products, N per result
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_acc  = 0;
                m_cnt  = 0;
                m_ovf  = 1'b0;
                m_hold = 1'b0;
                exp_q.delete();
            end else if (m_hold) begin
                if (bus.out_ready) m_hold = 1'b0;
            end else if (bus.in_valid) begin
                int s;
                s = m_acc + int'(bus.in_prod);
                if (s > MAXV) begin
                    m_ovf = 1'b1;
`ifdef MULT_ACC_SAT_EN
                    s = MAXV;
`else
                    s = s - (MAXV + 1);
`endif
                end
                m_cnt++;
                if (m_cnt == N) begin
                    exp_q.push_back('{s, m_ovf});
                    m_acc  = 0;
                    m_cnt  = 0;
                    m_ovf  = 1'b0;
                    m_hold = 1'b1;
                end else begin
                    m_acc = s;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
                chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("result_queue", 32'(exp_q.size()), 32'd1);
                    end else begin
                        chk("out_sum", 32'(bus.out_sum), 32'(exp_q[0].sum));
                        chk("out_ovf", 32'(bus.out_ovf), 32'(exp_q[0].ovf));
                        if (bus.out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic d2_pair(input int a, input int b,
                           output logic [7:0] s, output logic o);
        bus2.in_valid = 1'b1;
        bus2.in_prod  = 8'(a);
        cyc();
        bus2.in_prod = 8'(b);
        cyc();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("d2_out_valid", 32'(bus2.out_valid), 32'd1);
        s = bus2.out_sum;
        o = bus2.out_ovf;
        cyc();
    endtask

    initial begin
        logic [7:0] s2;
        logic       o2;
        logic [8:0] r;
        int         a;
        int         b;

        bus.in_valid   = 1'b0;
        bus.in_prod    = 8'd0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_prod   = 8'd0;
        bus2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_d2_in_ready", 32'(bus2.in_ready), 32'd1);
        mon_en = 1'b1;
        cyc();

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_prod   = 8'd225;
        repeat (4) cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_sum", 32'(bus.out_sum), 32'd900);
        chk("b2b_ovf", 32'(bus.out_ovf), 32'd0);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_bubble", 32'(bus.in_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("b2b_ready_back", 32'(bus.in_ready), 32'd1);
        chk("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
        cyc();

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.in_prod = 8'(k);
            cyc();
        end
        bus.in_prod = 8'd7;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum", 32'(bus.out_sum), 32'd10);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        repeat (4) cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_sum", 32'(bus.out_sum), 32'd28);
        cyc();

        bus.in_valid = 1'b1;
        bus.in_prod  = 8'd1;
        cyc();
        bus.in_prod = 8'd0;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_prod  = 8'd99;
        repeat (3) cyc();
        bus.in_valid = 1'b1;
        bus.in_prod  = 8'd2;
        cyc();
        bus.in_prod = 8'd3;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("gap_sum", 32'(bus.out_sum), 32'd6);
        cyc();

        bus.in_valid = 1'b1;
        bus.in_prod  = 8'd50;
        repeat (2) cyc();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = 8'd1;
        repeat (4) cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_sum", 32'(bus.out_sum), 32'd4);
        chk("rst_mid_ovf", 32'(bus.out_ovf), 32'd0);
        cyc();

        d2_pair(200, 100, s2, o2);
`ifdef MULT_ACC_SAT_EN
        chk("ovf_sum", 32'(s2), 32'd255);
`else
        chk("ovf_sum", 32'(s2), 32'd44);
`endif
        chk("ovf_flag", 32'(o2), 32'd1);
        d2_pair(1, 1, s2, o2);
        chk("after_ovf_sum", 32'(s2), 32'd2);
        chk("after_ovf_flag", 32'(o2), 32'd0);
        repeat (30) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            r = ref8(a, b);
            d2_pair(a, b, s2, o2);
            chk("d2_rand_sum", 32'(s2), 32'(r[7:0]));
            chk("d2_rand_ovf", 32'(o2), 32'(r[8]));
        end

        repeat (3000) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.in_prod   = ($urandom_range(0, 3) == 0) ? 8'd225
                                                        : 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 99) < 60);
            rst           = ($urandom_range(0, 299) == 0);
            cyc();
        end

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
